// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Scoreboard slots hold {valid, rf_e, load, dest} for one in-flight instruction.
package hazard_pkg;

    localparam int HAZ_REG_AW = 4;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_EX  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;
    localparam fwd_sel_t FWD_WB  = 2'b11;

    typedef struct packed {
        logic                  valid;
        logic                  rf_e;
        logic                  load;
        logic [HAZ_REG_AW-1:0] dest;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    // A slot satisfies a source only if it really writes that register and the
    // source is actually read; the PC is never forwarded.
    function automatic logic slot_hits(input slot_t s,
                                       input logic [HAZ_REG_AW-1:0] src,
                                       input logic use_src,
                                       input logic [HAZ_REG_AW-1:0] pc_reg);
        return s.valid & s.rf_e & use_src & (s.dest == src) & (src != pc_reg);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage request bus and hazard-control responses between the core and the
// hazard/forwarding controller; the controller is the slave side.
interface hazard_forward_ctrl_if #(
    parameter int REG_AW = 4
);
    logic              run;
    logic [REG_AW-1:0] id_rn;
    logic [REG_AW-1:0] id_rm;
    logic [REG_AW-1:0] id_rd;
    logic              id_use_rn;
    logic              id_use_rm;
    logic              id_use_rd;
    logic [REG_AW-1:0] id_dest;
    logic              id_rf_e;
    logic              id_load;
    logic              branch_taken;

    logic              pc_le;
    logic              ifid_le;
    logic              ifid_flush;
    logic              id_nop;
    logic [1:0]        fwd_pa_sel;
    logic [1:0]        fwd_pb_sel;
    logic [1:0]        fwd_pd_sel;

    modport master (
        output run, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               id_dest, id_rf_e, id_load, branch_taken,
        input  pc_le, ifid_le, ifid_flush, id_nop,
               fwd_pa_sel, fwd_pb_sel, fwd_pd_sel
    );

    modport slave (
        input  run, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
               id_dest, id_rf_e, id_load, branch_taken,
        output pc_le, ifid_le, ifid_flush, id_nop,
               fwd_pa_sel, fwd_pb_sel, fwd_pd_sel
    );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Forwarding-mux select for one ID source operand: the youngest in-flight
// writer of the register wins (EX over MEM over WB), otherwise the register file.
module fwd_select
    import hazard_pkg::*;
#(
    parameter logic [HAZ_REG_AW-1:0] PC_REG = 4'hF
) (
    input  slot_t                 ex_slot,
    input  slot_t                 mem_slot,
    input  slot_t                 wb_slot,
    input  logic [HAZ_REG_AW-1:0] src,
    input  logic                  use_src,
    output fwd_sel_t              sel
);

    always_comb begin
        sel = FWD_RF;
        if (slot_hits(ex_slot, src, use_src, PC_REG)) begin
            sel = FWD_EX;
        end else if (slot_hits(mem_slot, src, use_src, PC_REG)) begin
            sel = FWD_MEM;
        end else if (slot_hits(wb_slot, src, use_src, PC_REG)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the five-stage core: EX/MEM/WB destination scoreboard,
// forwarding selects, load-use stall and taken-branch flush. Optional stall and
// flush counters are built when HAZ_STATS_EN is defined.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int              REG_AW = HAZ_REG_AW,
    parameter logic [REG_AW-1:0] PC_REG = 4'hF
) (
    input  logic                   clk,
    input  logic                   reset,
    hazard_forward_ctrl_if.slave   bus
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]            stall_count,
    output logic [31:0]            flush_count
`endif
);

    slot_t    ex_slot;
    slot_t    mem_slot;
    slot_t    wb_slot;
    slot_t    id_slot;
    fwd_sel_t pa_sel;
    fwd_sel_t pb_sel;
    fwd_sel_t pd_sel;
    logic     load_use_stall;

    fwd_select #(.PC_REG(PC_REG)) u_fwd_pa (
        .ex_slot (ex_slot),
        .mem_slot(mem_slot),
        .wb_slot (wb_slot),
        .src     (bus.id_rn),
        .use_src (bus.id_use_rn),
        .sel     (pa_sel)
    );

    fwd_select #(.PC_REG(PC_REG)) u_fwd_pb (
        .ex_slot (ex_slot),
        .mem_slot(mem_slot),
        .wb_slot (wb_slot),
        .src     (bus.id_rm),
        .use_src (bus.id_use_rm),
        .sel     (pb_sel)
    );

    fwd_select #(.PC_REG(PC_REG)) u_fwd_pd (
        .ex_slot (ex_slot),
        .mem_slot(mem_slot),
        .wb_slot (wb_slot),
        .src     (bus.id_rd),
        .use_src (bus.id_use_rd),
        .sel     (pd_sel)
    );

    // An EX-stage hit on any used source is exactly a select of FWD_EX.
    always_comb begin
        load_use_stall = ex_slot.load &&
                         ((pa_sel == FWD_EX) || (pb_sel == FWD_EX) || (pd_sel == FWD_EX));
    end

    always_comb begin
        id_slot       = BUBBLE;
        id_slot.valid = 1'b1;
        id_slot.rf_e  = bus.id_rf_e;
        id_slot.load  = bus.id_load;
        id_slot.dest  = bus.id_dest;
    end

    // Stall outranks a taken branch; the branch is simply seen again next cycle.
    always_comb begin
        bus.pc_le      = 1'b0;
        bus.ifid_le    = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.id_nop     = 1'b1;
        bus.fwd_pa_sel = FWD_RF;
        bus.fwd_pb_sel = FWD_RF;
        bus.fwd_pd_sel = FWD_RF;
        if (reset) begin
            bus.fwd_pa_sel = pa_sel;
            bus.fwd_pb_sel = pb_sel;
            bus.fwd_pd_sel = pd_sel;
            if (!bus.run) begin
                bus.id_nop = 1'b0;
            end else if (!load_use_stall) begin
                bus.pc_le      = 1'b1;
                bus.ifid_le    = 1'b1;
                bus.id_nop     = 1'b0;
                bus.ifid_flush = bus.branch_taken;
            end
        end
    end

    // While running, id_nop is asserted only by a stall, so a stall alone bubbles EX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_slot  <= BUBBLE;
            mem_slot <= BUBBLE;
            wb_slot  <= BUBBLE;
        end else if (bus.run) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= load_use_stall ? BUBBLE : id_slot;
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (load_use_stall && bus.run) begin
                stall_count <= stall_count + 32'd1;
            end
            if (bus.ifid_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scenario bench for hazard_forward_ctrl: per-cycle vectors with expected
// control/forward outputs queued at drive time and compared before the next edge.
module tb_hazard_forward_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.REG_AW(4)) bus();

`ifdef HAZ_STATS_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    hazard_forward_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus)
`ifdef HAZ_STATS_EN
        ,
        .stall_count(stall_count),
        .flush_count(flush_count)
`endif
    );

    localparam logic [3:0] C_NORM   = 4'b1100;
    localparam logic [3:0] C_STALL  = 4'b0001;
    localparam logic [3:0] C_FLUSH  = 4'b1110;
    localparam logic [3:0] C_FROZEN = 4'b0000;
    localparam logic [3:0] C_RESET  = 4'b0001;

    typedef struct {
        string      name;
        logic       rst;
        logic       run;
        logic       br;
        logic [3:0] rn;
        logic [3:0] rm;
        logic [3:0] rd;
        logic [2:0] uses;
        logic [3:0] dest;
        logic       rf_e;
        logic       load;
        logic [9:0] exp;
    } vec_t;

    logic [9:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int exp_stalls  = 0;
    int exp_flushes = 0;

    function automatic vec_t mk(input string name, input logic [3:0] ctrl,
                                input logic [1:0] pa, input logic [1:0] pb, input logic [1:0] pd,
                                input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                                input logic [2:0] uses, input logic [3:0] dest,
                                input logic rf_e, input logic load, input logic br,
                                input logic run, input logic rst);
        vec_t t;
        t.name = name; t.rst = rst; t.run = run; t.br = br;
        t.rn = rn; t.rm = rm; t.rd = rd; t.uses = uses;
        t.dest = dest; t.rf_e = rf_e; t.load = load;
        t.exp = {ctrl, pa, pb, pd};
        return t;
    endfunction

    function automatic logic [9:0] observed();
        return {bus.pc_le, bus.ifid_le, bus.ifid_flush, bus.id_nop,
                bus.fwd_pa_sel, bus.fwd_pb_sel, bus.fwd_pd_sel};
    endfunction

    task automatic applyStimulus(input vec_t t);
        reset            = t.rst;
        bus.run          = t.run;
        bus.branch_taken = t.br;
        bus.id_rn        = t.rn;
        bus.id_rm        = t.rm;
        bus.id_rd        = t.rd;
        bus.id_use_rn    = t.uses[2];
        bus.id_use_rm    = t.uses[1];
        bus.id_use_rd    = t.uses[0];
        bus.id_dest      = t.dest;
        bus.id_rf_e      = t.rf_e;
        bus.id_load      = t.load;
        exp_q.push_back(t.exp);
        if (t.rst && t.run && t.exp[9:6] == C_STALL) exp_stalls++;
        if (t.exp[9:6] == C_FLUSH) exp_flushes++;
    endtask

    task automatic test_reset();
        vec_t tv[$];
        logic [9:0] got, expv;
        for (int i = 0; i < 3; i++)
            tv.push_back(mk("reset_hold", C_RESET, 0,0,0, 1,1,1, 3'b111, 1, 1,1, 1, 1, 0));
        tv.push_back(mk("reset_release", C_NORM, 0,0,0, 1,2,3, 3'b111, 0, 0,0, 0, 1, 1));
        foreach (tv[i]) begin
            @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
    endtask

    task automatic test_forward();
        vec_t tv[$];
        logic [9:0] got, expv;
        tv.push_back(mk("add_r1",   C_NORM, 0,0,0, 0,0,0, 3'b000, 1, 1,0, 0, 1, 1));
        tv.push_back(mk("fwd_ex",   C_NORM, 1,0,0, 1,0,0, 3'b100, 0, 0,0, 0, 1, 1));
        tv.push_back(mk("fwd_mem",  C_NORM, 2,0,0, 1,0,0, 3'b100, 0, 0,0, 0, 1, 1));
        tv.push_back(mk("fwd_wb",   C_NORM, 3,0,0, 1,0,0, 3'b100, 0, 0,0, 0, 1, 1));
        tv.push_back(mk("fwd_rf",   C_NORM, 0,0,0, 1,0,0, 3'b100, 0, 0,0, 0, 1, 1));
        foreach (tv[i]) begin
            @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
    endtask

    task automatic test_load_use();
        vec_t tv[$];
        logic [9:0] got, expv;
        tv.push_back(mk("ldr_r2",     C_NORM,  0,0,0, 0,0,0, 3'b000, 2, 1,1, 0, 1, 1));
        tv.push_back(mk("lu_stall",   C_STALL, 0,1,0, 0,2,0, 3'b010, 5, 1,0, 0, 1, 1));
        tv.push_back(mk("lu_release", C_NORM,  0,2,0, 0,2,0, 3'b010, 5, 1,0, 0, 1, 1));
        tv.push_back(mk("lu_after",   C_NORM,  1,3,0, 5,2,0, 3'b110, 0, 0,0, 0, 1, 1));
        foreach (tv[i]) begin
            @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
    endtask

    task automatic test_priority();
        vec_t tv[$];
        logic [9:0] got, expv;
        tv.push_back(mk("w_r3a",    C_NORM, 0,0,0, 0,0,0,  3'b000, 3,  1,0, 0, 1, 1));
        tv.push_back(mk("w_r9",     C_NORM, 0,0,0, 0,0,0,  3'b000, 9,  1,0, 0, 1, 1));
        tv.push_back(mk("w_r3b",    C_NORM, 0,0,0, 0,0,0,  3'b000, 3,  1,0, 0, 1, 1));
        tv.push_back(mk("pri_ex",   C_NORM, 0,0,1, 0,0,3,  3'b001, 15, 1,0, 0, 1, 1));
        tv.push_back(mk("pc_never", C_NORM, 0,2,0, 15,3,0, 3'b110, 0,  0,0, 0, 1, 1));
        tv.push_back(mk("use_gate", C_NORM, 0,3,0, 3,3,0,  3'b010, 0,  0,0, 0, 1, 1));
        foreach (tv[i]) begin
            @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
    endtask

    task automatic test_branch();
        vec_t tv[$];
        logic [9:0] got, expv;
        tv.push_back(mk("br_flush",       C_FLUSH, 0,0,0, 0,0,0, 3'b000, 14, 1,0, 1, 1, 1));
        tv.push_back(mk("br_one_cycle",   C_NORM,  0,0,0, 0,0,0, 3'b000, 0,  0,0, 0, 1, 1));
        tv.push_back(mk("ldr_r4",         C_NORM,  0,0,0, 0,0,0, 3'b000, 4,  1,1, 0, 1, 1));
        tv.push_back(mk("br_stalled",     C_STALL, 1,0,0, 4,0,0, 3'b100, 14, 1,0, 1, 1, 1));
        tv.push_back(mk("br_after_stall", C_FLUSH, 2,0,0, 4,0,0, 3'b100, 14, 1,0, 1, 1, 1));
        tv.push_back(mk("br_done",        C_NORM,  0,0,0, 0,0,0, 3'b000, 0,  0,0, 0, 1, 1));
        foreach (tv[i]) begin
            @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t tv[$];
        logic [9:0] got, expv;
        tv.push_back(mk("b2b_ldr_r2",     C_NORM,  0,0,0, 0,0,0, 3'b000, 2, 1,1, 0, 1, 1));
        tv.push_back(mk("b2b_dep_ldr",    C_STALL, 1,0,0, 2,0,0, 3'b100, 3, 1,1, 0, 1, 1));
        tv.push_back(mk("b2b_dep_ldr_go", C_NORM,  2,0,0, 2,0,0, 3'b100, 3, 1,1, 0, 1, 1));
        tv.push_back(mk("b2b_use",        C_STALL, 0,1,0, 0,3,0, 3'b010, 6, 1,0, 0, 1, 1));
        tv.push_back(mk("b2b_use_go",     C_NORM,  0,2,0, 0,3,0, 3'b010, 6, 1,0, 0, 1, 1));
        tv.push_back(mk("b2b_clear",      C_NORM,  0,0,0, 0,0,0, 3'b000, 0, 0,0, 0, 1, 1));
        foreach (tv[i]) begin
            @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
    endtask

    task automatic test_run_freeze();
        vec_t tv[$];
        logic [9:0] got, expv;
        tv.push_back(mk("frz_w_r6", C_NORM, 0,0,0, 0,0,0, 3'b000, 6, 1,0, 0, 1, 1));
        for (int i = 0; i < 3; i++)
            tv.push_back(mk("frz_hold", C_FROZEN, 1,0,0, 6,0,0, 3'b100, 7, 1,1, 1, 0, 1));
        tv.push_back(mk("frz_resume",   C_NORM,   1,0,0, 6,0,0, 3'b100, 0, 0,0, 0, 1, 1));
        tv.push_back(mk("frz_advanced", C_NORM,   2,0,0, 6,0,0, 3'b100, 0, 0,0, 0, 1, 1));
        tv.push_back(mk("frz_ldr_r8",   C_NORM,   0,0,0, 0,0,0, 3'b000, 8, 1,1, 0, 1, 1));
        tv.push_back(mk("frz_lu_hold",  C_FROZEN, 0,1,0, 0,8,0, 3'b010, 0, 0,0, 0, 0, 1));
        tv.push_back(mk("frz_lu_stall", C_STALL,  0,1,0, 0,8,0, 3'b010, 0, 0,0, 0, 1, 1));
        tv.push_back(mk("frz_lu_go",    C_NORM,   0,2,0, 0,8,0, 3'b010, 0, 0,0, 0, 1, 1));
        foreach (tv[i]) begin
            @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
    endtask

`ifdef HAZ_STATS_EN
    task automatic test_stats();
        vec_t tv[$];
        logic [9:0] got, expv;
        @(negedge clk);
        vectors++;
        if (stall_count !== 32'(exp_stalls)) begin
            miscompares++;
            $display("[TB] FAIL stall_count: got %0d expected %0d", stall_count, exp_stalls);
        end
        vectors++;
        if (flush_count !== 32'(exp_flushes)) begin
            miscompares++;
            $display("[TB] FAIL flush_count: got %0d expected %0d", flush_count, exp_flushes);
        end
        for (int i = 0; i < 5; i++)
            tv.push_back(mk("stats_frozen", C_FROZEN, 0,3,0, 0,8,0, 3'b010, 0, 0,0, 1, 0, 1));
        foreach (tv[i]) begin
            if (i != 0) @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
        @(negedge clk);
        vectors++;
        if (stall_count !== 32'(exp_stalls)) begin
            miscompares++;
            $display("[TB] FAIL stall_count_frozen: got %0d expected %0d", stall_count, exp_stalls);
        end
        vectors++;
        if (flush_count !== 32'(exp_flushes)) begin
            miscompares++;
            $display("[TB] FAIL flush_count_frozen: got %0d expected %0d", flush_count, exp_flushes);
        end
    endtask
`endif

    task automatic test_reset_mid_stall();
        vec_t tv[$];
        logic [9:0] got, expv;
        tv.push_back(mk("mid_ldr_r2",  C_NORM,  0,0,0, 0,0,0, 3'b000, 2, 1,1, 0, 1, 1));
        tv.push_back(mk("mid_stall",   C_STALL, 0,1,0, 0,2,0, 3'b010, 4, 1,0, 0, 1, 1));
        tv.push_back(mk("mid_reset",   C_RESET, 0,0,0, 0,2,0, 3'b010, 4, 1,0, 0, 1, 0));
        tv.push_back(mk("mid_release", C_NORM,  0,0,0, 0,2,0, 3'b010, 4, 1,0, 0, 1, 1));
        foreach (tv[i]) begin
            @(negedge clk);
            applyStimulus(tv[i]);
            #2;
            got = observed();
            expv = exp_q.pop_front();
            vectors++;
            if (got !== expv) begin
                miscompares++;
                $display("[TB] FAIL %s: got %b expected %b", tv[i].name, got, expv);
            end
        end
    endtask

    initial begin
        reset            = 1'b0;
        bus.run          = 1'b0;
        bus.branch_taken = 1'b0;
        bus.id_rn        = '0;
        bus.id_rm        = '0;
        bus.id_rd        = '0;
        bus.id_use_rn    = 1'b0;
        bus.id_use_rm    = 1'b0;
        bus.id_use_rd    = 1'b0;
        bus.id_dest      = '0;
        bus.id_rf_e      = 1'b0;
        bus.id_load      = 1'b0;
        test_reset();
        test_forward();
        test_load_use();
        test_priority();
        test_branch();
        test_back_to_back();
        test_run_freeze();
`ifdef HAZ_STATS_EN
        test_stats();
`endif
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
